cpu_thread_switch: RTL

- Per-CPU context-switch controller for the multi-threaded sha256crypt CPU.
- Drives the thread number, save strobe and load strobe into the per-thread state stores (flags, PC, registers).
- Selects the next runnable thread round-robin and sequences the switch: save the outgoing thread's context, then load the incoming thread's context.
- Tells the instruction pipeline when a thread is loaded and executing.

---
 rtl/cpu_thread_switch.sv | 124 ++++++++++++
 1 files changed

// File: rtl/cpu_thread_switch.sv
// Context-switch controller for one multi-threaded sha256crypt CPU.
// Round-robin thread selection and save/load sequencing of thread context.
module cpu_thread_switch #(
    parameter int N_THREADS     = 16,
    parameter int N_THREADS_MSB = $clog2(N_THREADS) - 1
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic [N_THREADS-1:0]   thread_ready,
    input  logic                   switch_req,
    output logic [N_THREADS_MSB:0] thread_num,
    output logic                   save_en,
    output logic                   load_en,
    output logic                   running,
    output logic                   switch_ack
);

    localparam int TW = N_THREADS_MSB + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        SAVE = 2'd3
    } state_t;

    state_t          state;
    state_t          state_d;
    logic [TW-1:0]   thread_num_d;
    logic            save_en_d;
    logic            load_en_d;
    logic            running_d;
    logic            switch_ack_d;
    logic            any_ready;
    logic [TW-1:0]   next_thread;

    // First ready thread after t, wrapping, with t itself checked last.
    function automatic logic [TW-1:0] next_of(
        input logic [TW-1:0]        t,
        input logic [N_THREADS-1:0] ready
    );
        logic [TW-1:0] sel;
        logic [TW-1:0] idx;
        sel = t;
        for (int i = N_THREADS; i >= 1; i--) begin
            idx = TW'((int'(t) + i) % N_THREADS);
            if (ready[idx]) begin
                sel = idx;
            end
        end
        return sel;
    endfunction

    assign any_ready   = |thread_ready;
    assign next_thread = next_of(thread_num, thread_ready);

    // State and registered outputs; reset parks thread_num so scans start at 0.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= IDLE;
            thread_num <= TW'(N_THREADS - 1);
            save_en    <= 1'b0;
            load_en    <= 1'b0;
            running    <= 1'b0;
            switch_ack <= 1'b0;
        end else begin
            state      <= state_d;
            thread_num <= thread_num_d;
            save_en    <= save_en_d;
            load_en    <= load_en_d;
            running    <= running_d;
            switch_ack <= switch_ack_d;
        end
    end

    // Next-state decision.
    always_comb begin
        state_d = state;
        unique case (state)
            IDLE: if (any_ready) state_d = LOAD;
            LOAD: state_d = RUN;
            RUN:  if (switch_req) state_d = SAVE;
            SAVE: state_d = any_ready ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered outputs.
    always_comb begin
        thread_num_d = thread_num;
        save_en_d    = 1'b0;
        load_en_d    = 1'b0;
        running_d    = running;
        switch_ack_d = 1'b0;
        unique case (state)
            IDLE: begin
                running_d = 1'b0;
                if (any_ready) begin
                    thread_num_d = next_thread;
                    load_en_d    = 1'b1;
                end
            end
            LOAD: begin
                running_d    = 1'b1;
                switch_ack_d = 1'b1;
            end
            RUN: begin
                if (switch_req) begin
                    save_en_d = 1'b1;
                    running_d = 1'b0;
                end
            end
            SAVE: begin
                running_d = 1'b0;
                if (any_ready) begin
                    thread_num_d = next_thread;
                    load_en_d    = 1'b1;
                end
            end
            default: running_d = 1'b0;
        endcase
    end

endmodule
